// File: rtl/nn_res_if.sv
// Result handshake bundle between nn_argmax_capture and its consumer.
// Carries res_margin only when NN_MARGIN_EN is defined.
interface nn_res_if #(
  parameter int W = 12
);
  logic                res_valid;
  logic                res_ready;
  logic [3:0]          res_idx;
  logic signed [W-1:0] res_val;
`ifdef NN_MARGIN_EN
  logic [W:0]          res_margin;

  modport master (
    output res_valid,
    output res_idx,
    output res_val,
    output res_margin,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_idx,
    input  res_val,
    input  res_margin,
    output res_ready
  );
`else
  modport master (
    output res_valid,
    output res_idx,
    output res_val,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_idx,
    input  res_val,
    output res_ready
  );
`endif
endinterface

// File: rtl/nn_argmax_capture.sv
// Settle, capture and serial argmax over the 10 NN outputs.
// Optional macro NN_MARGIN_EN adds best-minus-second margin output.
module nn_argmax_capture #(
  parameter int W      = 12,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic signed [W-1:0] in4,
  input  logic signed [W-1:0] in5,
  input  logic signed [W-1:0] in6,
  input  logic signed [W-1:0] in7,
  input  logic signed [W-1:0] in8,
  input  logic signed [W-1:0] in9,
  input  logic signed [W-1:0] in10,
  output logic                busy,
  nn_res_if.master            res
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [CW-1:0]       cnt;
  logic [3:0]          idx;
  logic signed [W-1:0] c [10];
  logic signed [W-1:0] ins [10];
  logic signed [W-1:0] cur;
  logic signed [W-1:0] best_val;
  logic [3:0]          best_idx;
  logic                win;

  always_comb begin
    ins[0] = in1;
    ins[1] = in2;
    ins[2] = in3;
    ins[3] = in4;
    ins[4] = in5;
    ins[5] = in6;
    ins[6] = in7;
    ins[7] = in8;
    ins[8] = in9;
    ins[9] = in10;
  end

  // scan index is 1-based class number; c[] is 0-based
  always_comb begin
    cur = c[0];
    for (int k = 0; k < 10; k++) begin
      if (idx == 4'(k + 1)) cur = c[k];
    end
  end

  assign win = (cur > best_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == LAST) nxt = S_CAPTURE;
      end
      S_CAPTURE: nxt = S_SCAN;
      S_SCAN: begin
        if (idx == 4'd10) nxt = S_DONE;
      end
      S_DONE: begin
        if (res.res_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      best_val <= '0;
      best_idx <= '0;
      for (int k = 0; k < 10; k++) c[k] <= '0;
    end else begin
      unique case (state)
        S_IDLE:   cnt <= '0;
        S_SETTLE: cnt <= cnt + 1'b1;
        S_CAPTURE: begin
          for (int k = 0; k < 10; k++) c[k] <= ins[k];
          best_val <= in1;
          best_idx <= 4'd1;
          idx      <= 4'd2;
        end
        S_SCAN: begin
          if (win) begin
            best_val <= cur;
            best_idx <= idx;
          end
          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef NN_MARGIN_EN
  localparam logic signed [W-1:0] VMIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] second_val;

  // runner-up: displaced best, or any value beating the current runner-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_val <= '0;
    end else if (state == S_CAPTURE) begin
      second_val <= VMIN;
    end else if (state == S_SCAN) begin
      if (win)                    second_val <= best_val;
      else if (cur > second_val)  second_val <= cur;
    end
  end

  assign res.res_margin = {best_val[W-1], best_val}
                        - {second_val[W-1], second_val};
`endif

  assign busy          = (state != S_IDLE);
  assign res.res_valid = (state == S_DONE);
  assign res.res_idx   = best_idx;
  assign res.res_val   = best_val;

endmodule

// File: tb/tb_nn_argmax_capture.sv
// Randomized bench for nn_argmax_capture (SETTLE=2 and SETTLE=0 instances).
module tb_nn_argmax_capture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st0 = 1'b0;
  logic st1 = 1'b0;
  logic rdy0 = 1'b0;
  logic rdy1 = 1'b0;
  logic busy0;
  logic busy1;
  logic signed [11:0] in_v [10];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nn_res_if #(.W(12)) rif0 ();
  nn_res_if #(.W(12)) rif1 ();

  assign rif0.res_ready = rdy0;
  assign rif1.res_ready = rdy1;

  nn_argmax_capture #(.W(12), .SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0),
    .in1(in_v[0]), .in2(in_v[1]), .in3(in_v[2]), .in4(in_v[3]),
    .in5(in_v[4]), .in6(in_v[5]), .in7(in_v[6]), .in8(in_v[7]),
    .in9(in_v[8]), .in10(in_v[9]),
    .busy(busy0), .res(rif0.master)
  );

  nn_argmax_capture #(.W(12), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
    .in1(in_v[0]), .in2(in_v[1]), .in3(in_v[2]), .in4(in_v[3]),
    .in5(in_v[4]), .in6(in_v[5]), .in7(in_v[6]), .in8(in_v[7]),
    .in9(in_v[8]), .in10(in_v[9]),
    .busy(busy1), .res(rif1.master)
  );

  logic               obs_valid [2];
  logic               obs_busy  [2];
  logic [3:0]         obs_idx   [2];
  logic signed [11:0] obs_val   [2];
  logic [12:0]        obs_mar   [2];

  always_comb begin
    obs_valid[0] = rif0.res_valid;
    obs_valid[1] = rif1.res_valid;
    obs_busy[0]  = busy0;
    obs_busy[1]  = busy1;
    obs_idx[0]   = rif0.res_idx;
    obs_idx[1]   = rif1.res_idx;
    obs_val[0]   = rif0.res_val;
    obs_val[1]   = rif1.res_val;
`ifdef NN_MARGIN_EN
    obs_mar[0]   = rif0.res_margin;
    obs_mar[1]   = rif1.res_margin;
`else
    obs_mar[0]   = '0;
    obs_mar[1]   = '0;
`endif
  end

  // reference: first index holding the maximum; runner-up excludes that slot
  function automatic void model(input int v[10], output int idx,
                                output int val, output int mar);
    int sec;
    val = -2048;
    foreach (v[j]) if (v[j] > val) val = v[j];
    idx = 0;
    for (int j = 9; j >= 0; j--) if (v[j] == val) idx = j + 1;
    sec = -2048;
    foreach (v[j]) if (j != idx - 1 && v[j] > sec) sec = v[j];
    mar = val - sec;
  endfunction

  function automatic void snap(output int v[10]);
    foreach (v[j]) v[j] = int'(in_v[j]);
  endfunction

  task automatic set_start(input int s, input logic b);
    if (s == 0) st0 = b;
    else        st1 = b;
  endtask

  task automatic set_ready(input int s, input logic b);
    if (s == 0) rdy0 = b;
    else        rdy1 = b;
  endtask

  // returns #1 after the accepting edge k
  task automatic pulse(input int s);
    @(posedge clk); #1;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
  endtask

  task automatic wait_valid(input int s, input int n0, output int n);
    n = n0;
    while (!obs_valid[s] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake(input int s);
    set_ready(s, 1'b1);
    @(posedge clk); #1;
    set_ready(s, 1'b0);
  endtask

  task automatic check_result(input int s, input string nm, input int lat,
                              input int elat, input int ei, input int ev,
                              input int em);
    logic [11:0] ev12;
    logic [12:0] em13;
    ev12 = ev[11:0];
    em13 = em[12:0];
    nvec++;
    if (lat !== elat) begin
      nerr++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, elat);
    end
    nvec++;
    if (obs_idx[s] !== ei[3:0]) begin
      nerr++;
      $display("FAIL %s idx: got %0d want %0d", nm, obs_idx[s], ei);
    end
    nvec++;
    if (obs_val[s] !== ev12) begin
      nerr++;
      $display("FAIL %s val: got %0d want %0d", nm, obs_val[s], ev);
    end
`ifdef NN_MARGIN_EN
    nvec++;
    if (obs_mar[s] !== em13) begin
      nerr++;
      $display("FAIL %s margin: got %0d want %0d", nm, obs_mar[s], em);
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    foreach (in_v[j]) in_v[j] = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      nvec++;
      if ({obs_busy[s], obs_valid[s], obs_idx[s], obs_val[s]} !== 18'd0) begin
        nerr++;
        $display("FAIL reset dut%0d: busy=%b valid=%b idx=%0d val=%0d want 0",
                 s, obs_busy[s], obs_valid[s], obs_idx[s], obs_val[s]);
      end
`ifdef NN_MARGIN_EN
      nvec++;
      if (obs_mar[s] !== 13'd0) begin
        nerr++;
        $display("FAIL reset margin dut%0d: got %0d want 0", s, obs_mar[s]);
      end
`endif
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int v[10];
    int ei, ev, em, n;
    foreach (in_v[j]) in_v[j] = 12'((j + 1) * 10);
    snap(v);
    model(v, ei, ev, em);
    pulse(0);
    wait_valid(0, 0, n);
    check_result(0, "basic", n, 12, ei, ev, em);
    handshake(0);
  endtask

  task automatic test_signed_ties;
    int v[10];
    int ei, ev, em, n;
    foreach (in_v[j]) in_v[j] = 12'h800;
    in_v[2] = 12'h7FF;
    in_v[6] = 12'h7FF;
    snap(v);
    model(v, ei, ev, em);
    pulse(0);
    wait_valid(0, 0, n);
    check_result(0, "ties", n, 12, ei, ev, em);
    handshake(0);
  endtask

  task automatic test_random;
    int v[10];
    int ei, ev, em, n, s;
    logic [31:0] r;
    logic [11:0] pick [5];
    pick[0] = 12'h800; pick[1] = 12'h7FF; pick[2] = 12'h000;
    pick[3] = 12'hFFF; pick[4] = 12'h001;
    for (int t = 0; t < 24; t++) begin
      s = t % 2;
      foreach (in_v[j]) begin
        r = $urandom;
        if (t % 3 == 2) in_v[j] = pick[$urandom_range(0, 4)];
        else            in_v[j] = r[11:0];
      end
      snap(v);
      model(v, ei, ev, em);
      pulse(s);
      wait_valid(s, 0, n);
      check_result(s, "random", n, (s == 0) ? 12 : 10, ei, ev, em);
      handshake(s);
    end
  endtask

  task automatic test_backpressure;
    int v[10];
    int ei, ev, em, n;
    logic [31:0] r;
    foreach (in_v[j]) begin
      r = $urandom;
      in_v[j] = r[11:0];
    end
    snap(v);
    model(v, ei, ev, em);
    pulse(0);
    wait_valid(0, 0, n);
    check_result(0, "bp_first", n, 12, ei, ev, em);
    for (int c = 0; c < 20; c++) begin
      if (c == 4) foreach (in_v[j]) in_v[j] = 12'h7FF;
      set_start(0, (c == 7 || c == 8) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      nvec++;
      if (!(obs_valid[0] === 1'b1 && obs_busy[0] === 1'b1)) begin
        nerr++;
        $display("FAIL bp hold: valid=%b busy=%b want 1 1",
                 obs_valid[0], obs_busy[0]);
      end
      check_result(0, "bp_hold", 12, 12, ei, ev, em);
    end
    set_start(0, 1'b1);
    handshake(0);
    set_start(0, 1'b0);
    nvec++;
    if (!(obs_valid[0] === 1'b0 && obs_busy[0] === 1'b0)) begin
      nerr++;
      $display("FAIL bp release: valid=%b busy=%b want 0 0",
               obs_valid[0], obs_busy[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (obs_busy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL bp no_queue: busy=%b want 0", obs_busy[0]);
    end
  endtask

  task automatic test_reset_mid_scan;
    int v[10];
    int ei, ev, em, n;
    foreach (in_v[j]) in_v[j] = 12'(100 + j);
    pulse(0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({obs_busy[0], obs_valid[0], obs_idx[0], obs_val[0]} !== 18'd0) begin
      nerr++;
      $display("FAIL midscan reset: busy=%b valid=%b idx=%0d val=%0d want 0",
               obs_busy[0], obs_valid[0], obs_idx[0], obs_val[0]);
    end
    #4 rst_n = 1'b1;
    foreach (in_v[j]) in_v[j] = -12'sd5;
    snap(v);
    model(v, ei, ev, em);
    pulse(1);
    wait_valid(1, 0, n);
    check_result(1, "settle0", n, 10, ei, ev, em);
    handshake(1);
  endtask

  task automatic test_capture_iso;
    int v[10];
    int ei, ev, em, n;
    foreach (in_v[j]) in_v[j] = '0;
    in_v[4] = 12'sd500;
    snap(v);
    model(v, ei, ev, em);
    pulse(0);
    repeat (3) @(posedge clk);
    #1;
    in_v[4] = '0;
    in_v[8] = 12'sd900;
    wait_valid(0, 3, n);
    check_result(0, "capture_iso", n, 12, ei, ev, em);
    handshake(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_ties();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
    test_capture_iso();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
